uart_tx_sched: RTL and testbench

Round-robin scheduler that shares one UART byte transmitter between `N_REQ` requesters (key scanner, status reporter, loopback echo, etc.). It grants one requester at a time and issues a single-cycle launch pulse with the granted byte. It then holds the transmitter exclusively by counting baud ticks until the frame plus an inter-frame gap has elapsed. It sits between the requesting blocks and the transmitter/baud-generator pair on the UART path.

---
 rtl/uart_tx_sched.sv | 203 ++++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART byte transmitter
// between N_REQ requesters. It grants one requester, issues a one-clk launch
// pulse with the granted byte, then holds the transmitter for FRAME_TICKS
// plus GAP_TICKS baud ticks before it evaluates requests again.
//
// Optional feature: define UART_SCHED_TIMEOUT_EN to add a watchdog that
// aborts a frame whose baud ticks stall for TIMEOUT_CYCLES clk cycles.
//
// Parameter constraints: N_REQ in 2..8, IDW == clog2(N_REQ),
// FRAME_TICKS in 1..15, GAP_TICKS in 0..15.
module uart_tx_sched #(
    parameter int N_REQ          = 4,
    parameter int IDW            = 2,
    parameter int FRAME_TICKS    = 11,
    parameter int GAP_TICKS      = 1,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   ack,
    input  logic               clk_bps,
    output logic               tx_valid,
    output logic [7:0]         tx_data,
    output logic               busy,
    output logic [IDW-1:0]     grant_id,
    output logic               timeout_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_GAP    = 2'd3;

    localparam logic [3:0] FRAME_LAST = 4'(FRAME_TICKS - 1);
    localparam logic [3:0] GAP_LAST   = (GAP_TICKS > 0) ? 4'(GAP_TICKS - 1) : 4'd0;
    localparam bit         HAS_GAP    = (GAP_TICKS > 0);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [3:0]       tick_cnt;
    logic [IDW-1:0]   last;

    logic             win_valid;
    logic [IDW-1:0]   win_id;
    logic [7:0]       win_byte;
    logic [N_REQ-1:0] win_onehot;

    logic             frame_end;
    logic             gap_end;
    logic             wd_expire;
    logic             grant;
    logic             release_bus;

    // Round-robin winner: search upward from last+1, wrapping at N_REQ-1.
    always_comb begin
        int idx;
        idx       = 0;
        win_valid = 1'b0;
        win_id    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last) + k) % N_REQ;
            if (!win_valid && req[idx]) begin
                win_valid = 1'b1;
                win_id    = IDW'(idx);
            end
        end
    end

    // Byte and one-hot acknowledge belonging to the current winner.
    always_comb begin
        win_byte   = req_data[8*int'(win_id) +: 8];
        win_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << win_id;
    end

    // A baud tick on the last count of a phase is consumed by that exit.
    assign frame_end   = (state == S_WAIT) && clk_bps && (tick_cnt == FRAME_LAST);
    assign gap_end     = (state == S_GAP) && clk_bps && (tick_cnt == GAP_LAST);
    assign grant       = (state == S_IDLE) && win_valid;
    assign release_bus = (frame_end && !HAS_GAP) || gap_end || wd_expire;

`ifdef UART_SCHED_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wd_cnt;

    // Watchdog counts clk cycles since launch; the launch cycle counts as one.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= 16'd0;
        end else if (state == S_LAUNCH) begin
            wd_cnt <= 16'd1;
        end else if (state == S_WAIT) begin
            wd_cnt <= wd_cnt + 16'd1;
        end
    end

    // A frame that ends on the same edge wins over the watchdog.
    assign wd_expire = (state == S_WAIT) && !frame_end && (wd_cnt == WD_LAST);

    // One-clk abort pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= wd_expire;
        end
    end
`else
    assign wd_expire   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (win_valid) begin
                    state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (frame_end) begin
                    state_next = HAS_GAP ? S_GAP : S_IDLE;
                end else if (wd_expire) begin
                    state_next = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_end) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Baud tick counter, shared by WAIT and GAP; ticks in LAUNCH are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= 4'd0;
        end else if (state == S_LAUNCH || frame_end || gap_end || wd_expire) begin
            tick_cnt <= 4'd0;
        end else if ((state == S_WAIT || state == S_GAP) && clk_bps) begin
            tick_cnt <= tick_cnt + 4'd1;
        end
    end

    // Launch and acknowledge pulses, exactly one clk wide and coincident.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_valid <= 1'b0;
            ack      <= '0;
        end else if (grant) begin
            tx_valid <= 1'b1;
            ack      <= win_onehot;
        end else begin
            tx_valid <= 1'b0;
            ack      <= '0;
        end
    end

    // Grant bookkeeping; tx_data and grant_id hold until the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data  <= 8'h00;
            grant_id <= '0;
            last     <= IDW'(N_REQ - 1);
        end else if (grant) begin
            tx_data  <= win_byte;
            grant_id <= win_id;
            last     <= win_id;
        end
    end

    // Transmitter ownership flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
        end else if (grant) begin
            busy <= 1'b1;
        end else if (release_bus) begin
            busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed testbench for uart_tx_sched: one instance with default timing and
// one with GAP_TICKS=0, sharing clock, reset and request bytes.
module tb_uart_tx_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] req_data;

    logic [3:0]  req;
    logic        clk_bps;
    logic [3:0]  ack;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        busy;
    logic [1:0]  grant_id;
    logic        timeout_err;

    logic [3:0]  req_b;
    logic        clk_bps_b;
    logic [3:0]  ack_b;
    logic        tx_valid_b;
    logic [7:0]  tx_data_b;
    logic        busy_b;
    logic [1:0]  grant_id_b;
    logic        timeout_err_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_sched #(
        .N_REQ(4), .IDW(2), .FRAME_TICKS(11), .GAP_TICKS(1), .TIMEOUT_CYCLES(100)
    ) u_dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
        .clk_bps(clk_bps), .tx_valid(tx_valid), .tx_data(tx_data), .busy(busy),
        .grant_id(grant_id), .timeout_err(timeout_err)
    );

    uart_tx_sched #(
        .N_REQ(4), .IDW(2), .FRAME_TICKS(11), .GAP_TICKS(0), .TIMEOUT_CYCLES(65535)
    ) u_dut_g0 (
        .clk(clk), .rst(rst), .req(req_b), .req_data(req_data), .ack(ack_b),
        .clk_bps(clk_bps_b), .tx_valid(tx_valid_b), .tx_data(tx_data_b), .busy(busy_b),
        .grant_id(grant_id_b), .timeout_err(timeout_err_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Called in the LAUNCH cycle; ends right after the n-th tick edge.
    task automatic serve_a(input int n);
        step();
        for (int i = 0; i < n; i++) begin
            clk_bps = 1'b1;
            step();
            clk_bps = 1'b0;
            if (i < n - 1) step();
        end
    endtask

    task automatic serve_b(input int n);
        step();
        for (int i = 0; i < n; i++) begin
            clk_bps_b = 1'b1;
            step();
            clk_bps_b = 1'b0;
            if (i < n - 1) step();
        end
    endtask

    task automatic check_grant(input string tag, input logic [3:0] exp_ack, input logic [1:0] exp_id,
                               input logic [7:0] exp_byte);
        check({tag, "_ack"}, 32'(ack), 32'(exp_ack));
        check({tag, "_tx_valid"}, 32'(tx_valid), 32'd1);
        check({tag, "_grant_id"}, 32'(grant_id), 32'(exp_id));
        check({tag, "_tx_data"}, 32'(tx_data), 32'(exp_byte));
    endtask

    initial begin
        int busy_low;
        int err_seen;
        rst       = 1'b1;
        req       = 4'b0000;
        req_b     = 4'b0000;
        clk_bps   = 1'b0;
        clk_bps_b = 1'b0;
        req_data  = {8'h33, 8'hA5, 8'h22, 8'h11};
        step();
        step();
        rst = 1'b0;

        // Reset values
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);

        // Single request, baud tick every 16 clk
        req = 4'b0100;
        step();
        check_grant("single", 4'b0100, 2'd2, 8'hA5);
        check("single_busy", 32'(busy), 32'd1);
        req = 4'b0000;
        step();
        check("single_launch_tx_valid", 32'(tx_valid), 32'd0);
        check("single_launch_ack", 32'(ack), 32'd0);
        for (int t = 1; t <= 12; t++) begin
            repeat (15) step();
            clk_bps = 1'b1;
            step();
            clk_bps = 1'b0;
            check($sformatf("single_busy_tick%0d", t), 32'(busy), (t < 12) ? 32'd1 : 32'd0);
        end
        check("single_tx_data_hold", 32'(tx_data), 32'hA5);

        // Round-robin fairness from reset
        do_reset();
        req = 4'b1111;
        step();
        check_grant("rr0", 4'b0001, 2'd0, 8'h11);
        req = 4'b1110;
        serve_a(12);
        check("rr0_busy_end", 32'(busy), 32'd0);
        step();
        check_grant("rr1", 4'b0010, 2'd1, 8'h22);
        req = 4'b1100;
        serve_a(12);
        step();
        check_grant("rr2", 4'b0100, 2'd2, 8'hA5);
        req = 4'b1000;
        serve_a(12);
        step();
        check_grant("rr3", 4'b1000, 2'd3, 8'h33);
        req = 4'b0000;
        serve_a(12);
        check("rr3_busy_end", 32'(busy), 32'd0);
        req = 4'b1001;
        step();
        check_grant("rr_wrap0", 4'b0001, 2'd0, 8'h11);
        req = 4'b1000;
        serve_a(12);
        step();
        check_grant("rr_wrap3", 4'b1000, 2'd3, 8'h33);
        req = 4'b0000;
        serve_a(12);

        // Request raised while another frame is in flight
        req = 4'b0001;
        step();
        check_grant("pend0", 4'b0001, 2'd0, 8'h11);
        req = 4'b0000;
        step();
        req = 4'b0010;
        for (int i = 1; i <= 12; i++) begin
            clk_bps = 1'b1;
            step();
            clk_bps = 1'b0;
            check($sformatf("pend_no_ack_t%0d", i), 32'(ack), 32'd0);
            if (i < 12) begin
                step();
                check($sformatf("pend_no_valid_t%0d", i), 32'(tx_valid), 32'd0);
            end
        end
        check("pend_busy_fall", 32'(busy), 32'd0);
        check("pend_no_early_ack", 32'(ack), 32'd0);
        step();
        check_grant("pend1", 4'b0010, 2'd1, 8'h22);
        req = 4'b0000;
        serve_a(12);

        // Reset mid-frame
        req = 4'b0100;
        step();
        check_grant("mid", 4'b0100, 2'd2, 8'hA5);
        req = 4'b0000;
        serve_a(3);
        check("mid_busy_before_rst", 32'(busy), 32'd1);
        do_reset();
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        check("mid_rst_tx_data", 32'(tx_data), 32'h00);
        check("mid_rst_grant_id", 32'(grant_id), 32'd0);
        req = 4'b0111;
        step();
        check_grant("mid_after", 4'b0001, 2'd0, 8'h11);
        req = 4'b0000;
        serve_a(12);

        // Stalled baud ticks
        req = 4'b1000;
        step();
        check_grant("stall", 4'b1000, 2'd3, 8'h33);
        req = 4'b0000;
`ifdef UART_SCHED_TIMEOUT_EN
        err_seen = 0;
        busy_low = 1;
        for (int k = 1; k <= 200; k++) begin
            step();
            if (timeout_err === 1'b1 && err_seen == 0) begin
                err_seen = k;
                busy_low = (busy === 1'b0) ? 1 : 0;
            end
        end
        check("wd_err_delay", 32'(err_seen), 32'd100);
        check("wd_busy_clear", 32'(busy_low), 32'd1);
`else
        busy_low = 0;
        err_seen = 0;
        for (int k = 1; k <= 1000; k++) begin
            step();
            if (busy !== 1'b1) busy_low++;
            if (timeout_err !== 1'b0) err_seen++;
        end
        check("stall_busy_low_cycles", 32'(busy_low), 32'd0);
        check("stall_timeout_err", 32'(err_seen), 32'd0);
`endif
        do_reset();

        // GAP_TICKS=0 instance
        req_b = 4'b0011;
        step();
        check("g0_first_ack", 32'(ack_b), 32'b0001);
        check("g0_first_valid", 32'(tx_valid_b), 32'd1);
        check("g0_first_data", 32'(tx_data_b), 32'h11);
        req_b = 4'b0010;
        step();
        for (int i = 1; i <= 11; i++) begin
            clk_bps_b = 1'b1;
            step();
            clk_bps_b = 1'b0;
            check($sformatf("g0_busy_tick%0d", i), 32'(busy_b), (i < 11) ? 32'd1 : 32'd0);
            if (i < 11) step();
        end
        check("g0_no_early_valid", 32'(tx_valid_b), 32'd0);
        step();
        check("g0_next_valid", 32'(tx_valid_b), 32'd1);
        check("g0_next_ack", 32'(ack_b), 32'b0010);
        check("g0_next_data", 32'(tx_data_b), 32'h22);
        check("g0_next_grant_id", 32'(grant_id_b), 32'd1);
        req_b = 4'b0000;
        serve_b(11);
        check("g0_idle_busy", 32'(busy_b), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
